// File: rtl/delay_tap_line.sv
// ---------------------------------------------------------------------------
// delay_tap_line
//
// Shared history shift register with NTAPS independently programmable taps.
// Each tap is either a pure delay (transport) or a de-glitching delay
// (inertial: a value must be seen for d+1 consecutive enabled samples before
// it propagates).
//
// Optional feature macro: DLY_GLITCH_CNT_EN
//   When defined, each tap gets a pending flag and an 8-bit saturating
//   rejected-pulse counter exposed on glitch_cnt. When undefined, the port
//   and all related logic are absent.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          clock enable; 0 freezes history, fill, dout and counters
//   din         WIDTH-bit data input (history position 0, combinational)
//   tap_dly     NTAPS x DW delay codes, tap k at [k*DW +: DW]; codes above
//               DEPTH-1 clamp to DEPTH-1
//   tap_mode    per-tap mode: 0 = transport, 1 = inertial
//   dout        NTAPS x WIDTH registered tap outputs, tap k at [k*WIDTH +: WIDTH]
//   valid       per-tap history-filled flag (fill > d_k); does not gate dout
//   glitch_cnt  NTAPS x 8 rejected-pulse counters (DLY_GLITCH_CNT_EN only)
// ---------------------------------------------------------------------------
module delay_tap_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    parameter int NTAPS = 4,
    localparam int DW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [WIDTH-1:0]       din,
    input  logic [NTAPS*DW-1:0]    tap_dly,
    input  logic [NTAPS-1:0]       tap_mode,
    output logic [NTAPS*WIDTH-1:0] dout,
    output logic [NTAPS-1:0]       valid
`ifdef DLY_GLITCH_CNT_EN
    ,
    output logic [NTAPS*8-1:0]     glitch_cnt
`endif
);

    localparam int FW = $clog2(DEPTH + 1);

    // History: h_w[0] is din, h_w[1..DEPTH-1] are the registered stages.
    logic [WIDTH-1:0] hist_q [1:DEPTH-1];
    logic [WIDTH-1:0] hist_d [1:DEPTH-1];
    logic [WIDTH-1:0] h_w    [DEPTH];

    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_d;

    logic [WIDTH-1:0] dout_q [NTAPS];
    logic [WIDTH-1:0] dout_d [NTAPS];

    logic [DW-1:0]    dsel    [NTAPS];
    logic [NTAPS-1:0] uniform;

`ifdef DLY_GLITCH_CNT_EN
    logic [NTAPS-1:0] pend_q;
    logic [NTAPS-1:0] pend_d;
    logic [7:0]       cnt_q [NTAPS];
    logic [7:0]       cnt_d [NTAPS];
`endif

    // Per-tap delay code, clamped so it can never address past the chain.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            dsel[k] = tap_dly[k*DW +: DW];
            if (int'(tap_dly[k*DW +: DW]) > DEPTH - 1) begin
                dsel[k] = DW'(DEPTH - 1);
            end
        end
    end

    always_comb begin
        h_w[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            h_w[i] = hist_q[i];
        end
    end

    // Shift chain and saturating fill counter.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (en) begin
            for (int i = 1; i < DEPTH; i++) begin
                hist_d[i] = h_w[i-1];
            end
            if (fill_q != FW'(DEPTH)) begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    // Inertial window test: h[0..d_k] all equal to h[0] (whole-word compare).
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            uniform[k] = 1'b1;
            for (int i = 1; i < DEPTH; i++) begin
                if ((i <= int'(dsel[k])) && (h_w[i] != h_w[0])) begin
                    uniform[k] = 1'b0;
                end
            end
        end
    end

    // Tap output update. An inertial tap moves only when its whole window
    // agrees on a value different from what it currently presents; with
    // d = 0 this reduces to the transport d = 0 behaviour.
    always_comb begin
        dout_d = dout_q;
`ifdef DLY_GLITCH_CNT_EN
        pend_d = pend_q;
        cnt_d  = cnt_q;
`endif
        if (en) begin
            for (int k = 0; k < NTAPS; k++) begin
                if (!tap_mode[k]) begin
                    dout_d[k] = h_w[dsel[k]];
`ifdef DLY_GLITCH_CNT_EN
                    pend_d[k] = 1'b0;
`endif
                end else if (uniform[k] && (h_w[0] != dout_q[k])) begin
                    dout_d[k] = h_w[0];
`ifdef DLY_GLITCH_CNT_EN
                    pend_d[k] = 1'b0;
                end else if (h_w[0] != dout_q[k]) begin
                    // A differing value is in flight but not yet accepted.
                    pend_d[k] = 1'b1;
                end else if (pend_q[k]) begin
                    // Input fell back to the held value before acceptance:
                    // that pulse was rejected.
                    pend_d[k] = 1'b0;
                    if (cnt_q[k] != 8'hFF) begin
                        cnt_d[k] = cnt_q[k] + 8'd1;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
            for (int i = 1; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            for (int k = 0; k < NTAPS; k++) begin
                dout_q[k] <= '0;
            end
`ifdef DLY_GLITCH_CNT_EN
            pend_q <= '0;
            for (int k = 0; k < NTAPS; k++) begin
                cnt_q[k] <= '0;
            end
`endif
        end else begin
            fill_q <= fill_d;
            hist_q <= hist_d;
            dout_q <= dout_d;
`ifdef DLY_GLITCH_CNT_EN
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
`endif
        end
    end

    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            dout[k*WIDTH +: WIDTH] = dout_q[k];
            valid[k]               = (int'(fill_q) > int'(dsel[k]));
        end
    end

`ifdef DLY_GLITCH_CNT_EN
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            glitch_cnt[k*8 +: 8] = cnt_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_delay_tap_line.sv
// ---------------------------------------------------------------------------
// tb_delay_tap_line
//
// Self-checking bench for delay_tap_line (WIDTH=4, DEPTH=8, NTAPS=4).
// Reference model keeps a log of the last DEPTH enabled samples (newest
// first) and derives every tap from that log. Honours DLY_GLITCH_CNT_EN.
// ---------------------------------------------------------------------------
module tb_delay_tap_line;

    localparam int W     = 4;
    localparam int DEPTH = 8;
    localparam int NT    = 4;
    localparam int DW    = 3;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              en;
    logic [W-1:0]      din;
    logic [NT*DW-1:0]  tap_dly;
    logic [NT-1:0]     tap_mode;
    logic [NT*W-1:0]   dout;
    logic [NT-1:0]     valid;
`ifdef DLY_GLITCH_CNT_EN
    logic [NT*8-1:0]   glitch_cnt;
`endif

    always #5 clk = ~clk;

    delay_tap_line #(.WIDTH(W), .DEPTH(DEPTH), .NTAPS(NT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .din      (din),
        .tap_dly  (tap_dly),
        .tap_mode (tap_mode),
        .dout     (dout),
        .valid    (valid)
`ifdef DLY_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [W-1:0] m_hist[$];     // m_hist[i] = sample taken i enabled edges ago
    int           m_fill;
    logic [W-1:0] m_dout [NT];
    bit           m_pend [NT];
    int           m_cnt  [NT];

    function automatic int dk(input int k);
        int v;
        v = int'(tap_dly[k*DW +: DW]);
        if (v > DEPTH - 1) v = DEPTH - 1;
        return v;
    endfunction

    function automatic logic [NT-1:0] m_valid();
        logic [NT-1:0] v;
        for (int k = 0; k < NT; k++) v[k] = (m_fill > dk(k));
        return v;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < DEPTH; i++) m_hist.push_back('0);
        m_fill = 0;
        for (int k = 0; k < NT; k++) begin
            m_dout[k] = '0;
            m_pend[k] = 1'b0;
            m_cnt[k]  = 0;
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] h0;
        if (!en) return;
        m_hist.push_front(din);
        void'(m_hist.pop_back());
        h0 = m_hist[0];
        for (int k = 0; k < NT; k++) begin
            int  d;
            bit  same;
            d = dk(k);
            if (!tap_mode[k]) begin
                m_dout[k] = m_hist[d];
                m_pend[k] = 1'b0;
            end else begin
                same = 1'b1;
                for (int i = 0; i <= d; i++) if (m_hist[i] != h0) same = 1'b0;
                if (same && (h0 != m_dout[k])) begin
                    m_dout[k] = h0;
                    m_pend[k] = 1'b0;
                end else if (h0 != m_dout[k]) begin
                    m_pend[k] = 1'b1;
                end else if (m_pend[k]) begin
                    m_pend[k] = 1'b0;
                    if (m_cnt[k] < 255) m_cnt[k]++;
                end
            end
        end
        if (m_fill < DEPTH) m_fill++;
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NT; k++) begin
            cmp($sformatf("%s dout%0d", tag, k), 32'(dout[k*W +: W]), 32'(m_dout[k]));
`ifdef DLY_GLITCH_CNT_EN
            cmp($sformatf("%s glitch%0d", tag, k), 32'(glitch_cnt[k*8 +: 8]), 32'(m_cnt[k]));
`endif
        end
        cmp($sformatf("%s valid", tag), 32'(valid), 32'(m_valid()));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_tap(input int k, input int d, input logic mode);
        tap_dly[k*DW +: DW] = DW'(d);
        tap_mode[k]         = mode;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic         v0;
        logic         v1;
    } vec_t;

    vec_t tv [16];

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        // Transport pulse table: tap0 d=0, tap1 d=3, pulse sampled at edge 10 only.
        tv[0]  = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b0};
        tv[1]  = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b0};
        tv[2]  = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b0};
        tv[3]  = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b1};
        tv[4]  = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b1};
        tv[5]  = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b1};
        tv[6]  = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b1};
        tv[7]  = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b1};
        tv[8]  = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b1};
        tv[9]  = '{4'd1, 4'd1, 4'd0, 1'b1, 1'b1};
        tv[10] = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b1};
        tv[11] = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b1};
        tv[12] = '{4'd0, 4'd0, 4'd1, 1'b1, 1'b1};
        tv[13] = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b1};
        tv[14] = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b1};
        tv[15] = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b1};

        en = 1'b0; din = '0; tap_dly = '0; tap_mode = '0;
        model_reset();

        // ---- reset and valid rise, all taps transport d=3 ----
        for (int k = 0; k < NT; k++) set_tap(k, 3, 1'b0);
        do_reset();
        en  = 1'b1;
        din = 4'd1;
        for (int e = 1; e <= 6; e++) begin
            step("vrise");
            cmp($sformatf("vrise valid e%0d", e), 32'(valid), (e >= 4) ? 32'hF : 32'h0);
        end
        // Async reset mid-pulse: outputs clear immediately, no clock needed.
        #3 rst_n = 1'b0;
        #1;
        cmp("midrst dout", 32'(dout), 32'h0);
        cmp("midrst valid", 32'(valid), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        cmp("inrst dout", 32'(dout), 32'h0);
        rst_n = 1'b1;
        din   = 4'd0;
        for (int e = 1; e <= 5; e++) begin
            step("postrst");
            cmp("postrst dout", 32'(dout), 32'h0);
        end

        // ---- transport table ----
        set_tap(0, 0, 1'b0);
        set_tap(1, 3, 1'b0);
        set_tap(2, 3, 1'b1);
        set_tap(3, 0, 1'b1);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            din = tv[i].din;
            step("tv");
            cmp($sformatf("tv%0d dout0", i), 32'(dout[0*W +: W]), 32'(tv[i].d0));
            cmp($sformatf("tv%0d dout1", i), 32'(dout[1*W +: W]), 32'(tv[i].d1));
            cmp($sformatf("tv%0d valid0", i), 32'(valid[0]), 32'(tv[i].v0));
            cmp($sformatf("tv%0d valid1", i), 32'(valid[1]), 32'(tv[i].v1));
        end

        // ---- inertial reject/pass, tap0 d=3 ----
        set_tap(0, 3, 1'b1);
        set_tap(1, 3, 1'b0);
        do_reset();
        for (int e = 1; e <= 32; e++) begin
            din = ((e == 5) || (e == 6) || ((e >= 20) && (e <= 24))) ? 4'd1 : 4'd0;
            step("inert");
            cmp($sformatf("inert e%0d dout0", e), 32'(dout[0*W +: W]),
                ((e >= 23) && (e <= 27)) ? 32'd1 : 32'd0);
        end
`ifdef DLY_GLITCH_CNT_EN
        cmp("inert glitch0", 32'(glitch_cnt[7:0]), 32'd1);
`endif

        // ---- enable freeze, tap0 transport d=2 ----
        set_tap(0, 2, 1'b0);
        do_reset();
        for (int e = 1; e <= 6; e++) begin
            din = (e % 2 == 1) ? 4'd1 : 4'd0;
            step("frz pre");
        end
        begin
            logic [W-1:0]  held_dout;
            logic [NT-1:0] held_valid;
            held_dout  = m_dout[0];
            held_valid = m_valid();
            en = 1'b0;
            for (int c = 0; c < 4; c++) begin
                din = W'($urandom);
                step("frz off");
                cmp("frz hold dout0", 32'(dout[0*W +: W]), 32'(held_dout));
                cmp("frz hold valid", 32'(valid), 32'(held_valid));
            end
        end
        en = 1'b1;
        exp_q.push_back(4'd1);   // sampled at enabled edge 5
        exp_q.push_back(4'd0);   // sampled at enabled edge 6
        for (int c = 0; c < 4; c++) begin
            din = 4'd0;
            step("frz resume");
            if (exp_q.size() > 0) begin
                cmp("frz resume dout0", 32'(dout[0*W +: W]), 32'(exp_q.pop_front()));
            end
        end

        // ---- delay change on a ramp, tap0 transport 5 -> 1 ----
        set_tap(0, 5, 1'b0);
        do_reset();
        din = 4'd0;
        for (int n = 0; n < 12; n++) begin
            step("ramp");
            din = W'(n + 1);
            if (n >= 5) cmp("ramp d5", 32'(dout[0*W +: W]), 32'(W'(din - 4'd6)));
        end
        set_tap(0, 1, 1'b0);
        for (int n = 0; n < 3; n++) begin
            step("ramp d1");
            din = din + 4'd1;
            cmp("ramp d1", 32'(dout[0*W +: W]), 32'(W'(din - 4'd2)));
        end

        // ---- 300 one-cycle glitches into inertial d=2 ----
        set_tap(0, 2, 1'b1);
        do_reset();
        for (int g = 0; g < 300; g++) begin
            din = 4'd1;
            step("sat hi");
            cmp("sat dout0 hi", 32'(dout[0*W +: W]), 32'd0);
            din = 4'd0;
            step("sat lo");
            cmp("sat dout0 lo", 32'(dout[0*W +: W]), 32'd0);
        end
`ifdef DLY_GLITCH_CNT_EN
        cmp("sat glitch0", 32'(glitch_cnt[7:0]), 32'd255);
`endif

        // ---- randomized against the model ----
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (c % 100 == 0) begin
                tap_dly  = NT*DW'($urandom);
                tap_mode = NT'($urandom);
            end
            if (c == 1000) do_reset();
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) din = W'($urandom);
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/delay_tap_line.md
# delay_tap_line

Synthesizable, clocked successor to the behavioural delay buffer: one input word is fed through a shared history shift register and presented on NTAPS independently programmable taps. Each tap runs in transport mode, a pure N-cycle delay, or inertial mode, where pulses shorter than the tap delay are rejected. It sits between stimulus/sensor inputs and downstream logic needing aligned, delayed or de-glitched copies of one signal.

## Interface
- WIDTH, 1: data word width in bits.
- DEPTH, 8: maximum delay in cycles, ≥2; DW = $clog2(DEPTH).
- NTAPS, 4: number of output taps.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  clock enable; 0 freezes all state.
- din  input  WIDTH  data input.
- tap_dly  input  NTAPS*DW  per-tap delay code d, tap k at [k*DW +: DW]; latency d+1 cycles; codes > DEPTH-1 clamp to DEPTH-1.
- tap_mode  input  NTAPS  per-tap mode, 0 = transport, 1 = inertial.
- dout  output  NTAPS*WIDTH  tap outputs, tap k at [k*WIDTH +: WIDTH], registered.
- valid  output  NTAPS  tap k history filled: fill > d_k.
- glitch_cnt  output  NTAPS*8  rejected-pulse counters; present only with DLY_GLITCH_CNT_EN.

## Operation
- History: h[0] = din, combinational. h[1..DEPTH-1] is a register chain; on each enabled edge h[i] <= h[i-1].
- fill: counter of enabled edges since reset, saturating at DEPTH; drives valid.
- Transport tap: on enabled edge dout_k <= h[d_k]; exact copy of din delayed d_k+1 cycles, every pulse passes.
- Inertial tap: on enabled edge, if h[0..d_k] all equal and differ from dout_k, dout_k <= h[0]; otherwise hold. A value must be present for d_k+1 consecutive enabled samples to propagate. For WIDTH > 1 equality is whole-word.
- d_k = 0 in inertial mode behaves identically to transport d = 0.
- Window contents after reset are zero, so early comparisons use zeros. valid flags this state and is not a gate on dout.
- tap_dly/tap_mode changes take effect on the next enabled edge with no flush. A transport tap may jump to the new tap position. An inertial tap only updates once its new window is uniform.
- en = 0: history, fill, dout and counters hold; din is ignored.

## Timing
- Reset (rst_n low, async): h[*] = 0, dout = 0, fill = 0, valid = 0, glitch_cnt = 0, pending = 0. These hold until the first enabled edge after release.
- Latency, both modes: din value sampled at enabled edge t appears on dout_k after edge t+d_k.
- valid_k rises after the (d_k+1)th enabled edge after reset.
- All taps update on the same edge; there is no inter-tap skew.
- Reset asserted mid-pulse discards the pulse; no partial output.

## Configuration
- DLY_GLITCH_CNT_EN defined:
  - Each tap keeps a pending flag and an 8-bit saturating counter, glitch_cnt_k.
  - Enabled edge, inertial tap: if dout updates, pending <= 0. Else if h[0] != dout_k, pending <= 1. Else if pending, glitch_cnt_k++ (saturating at 255) and pending <= 0.
  - Transport taps never count.
- DLY_GLITCH_CNT_EN undefined: the glitch_cnt port and all related logic are absent. Tap behaviour is otherwise identical.

## Test plan
- Reset: rst_n = 0 mid-run with din = 1 -> dout = 0 and valid = 0 immediately; after release with en = 1 and d = 3, valid_k rises after the 4th edge.
- Transport: tap0 d = 0, tap1 d = 3, WIDTH = 1; 1-cycle pulse on din at edge 10 -> dout0 high after edge 10 only, dout1 high after edge 13 only.
- Inertial reject/pass: d = 3, mode = 1; 2-cycle pulse -> dout stays 0; then a 5-cycle pulse starting at edge 20 -> dout rises after edge 23 and falls after edge 28. With the macro, glitch_cnt = 1.
- Enable freeze: transport d = 2, toggle din, then en = 0 for 4 cycles while din changes -> dout and valid constant; on resume the sequence continues from where it stopped.
- Delay change: transport tap, stable ramp on din (WIDTH = 4, values 0,1,2…), d switched 5 -> 1 -> dout jumps from din-6 to din-2 on the next edge.
- Saturation (macro on): 300 one-cycle glitches into an inertial tap with d = 2 -> glitch_cnt = 255, dout = 0 throughout.
